// File: rtl/fft_stage01_bfly_if.sv
// ---------------------------------------------------------------------------
// fft_stage01_bfly_if
// Bus bundle for the FFT stage-01 radix-2 butterfly.
//   din_valid               beat qualifier from the stage-00 twiddle stream
//   din_re / din_im         LANES x WIDTH signed samples, lane 0..LANES-1
//   dout_sum_re/_im         LANES x (WIDTH+1) stored + new
//   dout_diff_re/_im        LANES x (WIDTH+1) stored - new
//   dout_valid              one pulse per butterfly output beat
//   frame_done              pulses with the last output beat of a frame
//   sat_hit                 any lane clamped on this beat
// Modports: master drives the input stream, slave is the butterfly.
// ---------------------------------------------------------------------------
interface fft_stage01_bfly_if #(
  parameter int WIDTH = 10,
  parameter int LANES = 16
);
  logic                          din_valid;
  logic [LANES-1:0][WIDTH-1:0]   din_re;
  logic [LANES-1:0][WIDTH-1:0]   din_im;
  logic [LANES-1:0][WIDTH:0]     dout_sum_re;
  logic [LANES-1:0][WIDTH:0]     dout_sum_im;
  logic [LANES-1:0][WIDTH:0]     dout_diff_re;
  logic [LANES-1:0][WIDTH:0]     dout_diff_im;
  logic                          dout_valid;
  logic                          frame_done;
  logic                          sat_hit;

  modport master (
    output din_valid, din_re, din_im,
    input  dout_sum_re, dout_sum_im, dout_diff_re, dout_diff_im,
    input  dout_valid, frame_done, sat_hit
  );

  modport slave (
    input  din_valid, din_re, din_im,
    output dout_sum_re, dout_sum_im, dout_diff_re, dout_diff_im,
    output dout_valid, frame_done, sat_hit
  );
endinterface

// File: rtl/fft_stage01_bfly.sv
// ---------------------------------------------------------------------------
// fft_stage01_bfly
// Radix-2 DIF stage 01 of the 512-point, 16-lane FFT pipeline. Each block of
// 2*DIST_CYC accepted beats is split in two halves: the first half is stored
// in a delay buffer, and each beat of the second half is combined with the
// stored beat DIST_CYC positions earlier to produce registered sum/diff.
//
// Ports
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   slave modport of fft_stage01_bfly_if (input stream, butterfly out)
//
// Optional feature macro: FFT_STAGE01_SAT_EN
//   defined   : results clamped to the signed WIDTH range, sat_hit reported
//   undefined : full-precision WIDTH+1 results, sat_hit stays 0
//
// DIST_CYC and FRAME_CYC are expected to be powers of two (the buffer slot is
// taken from the low phase bits in both halves of the block).
// ---------------------------------------------------------------------------
module fft_stage01_bfly #(
  parameter int WIDTH     = 10,
  parameter int LANES     = 16,
  parameter int DIST_CYC  = 8,
  parameter int FRAME_CYC = 32
) (
  input  logic               clk,
  input  logic               rst,
  fft_stage01_bfly_if.slave  bus
);

  localparam int PW = $clog2(2 * DIST_CYC);
  localparam int AW = $clog2(DIST_CYC);
  localparam int FW = $clog2(FRAME_CYC);

  localparam logic [PW-1:0] PH_LAST = PW'(2 * DIST_CYC - 1);
  localparam logic [PW-1:0] PH_BFLY = PW'(DIST_CYC);
  localparam logic [FW-1:0] FR_LAST = FW'(FRAME_CYC - 1);

  typedef logic [LANES-1:0][WIDTH-1:0] beat_t;
  typedef logic [LANES-1:0][WIDTH:0]   res_t;

  logic [PW-1:0] phase_q, phase_d;
  logic [FW-1:0] frame_q, frame_d;

  beat_t buf_re_q [DIST_CYC];
  beat_t buf_im_q [DIST_CYC];

  res_t sum_re_q,  sum_re_d;
  res_t sum_im_q,  sum_im_d;
  res_t diff_re_q, diff_re_d;
  res_t diff_im_q, diff_im_d;
  logic valid_q, valid_d;
  logic done_q,  done_d;
  logic sat_q,   sat_d;

  logic          accept;
  logic          in_bfly;
  logic [AW-1:0] slot;

  // Per-lane full-precision intermediates (rewritten every lane iteration)
  logic signed [WIDTH:0] sr, si, dr, di;

  assign accept  = bus.din_valid;
  assign in_bfly = (phase_q >= PH_BFLY);
  // Write slot in FILL and read slot in BFLY are both the low phase bits.
  assign slot    = phase_q[AW-1:0];

  // Sign-extend one WIDTH-bit sample to WIDTH+1 bits.
  function automatic logic signed [WIDTH:0] sext(input logic [WIDTH-1:0] v);
    return $signed({v[WIDTH-1], v});
  endfunction

`ifdef FFT_STAGE01_SAT_EN
  localparam logic signed [WIDTH:0] SAT_MAX = (WIDTH+1)'((2 ** (WIDTH-1)) - 1);
  localparam logic signed [WIDTH:0] SAT_MIN = ~SAT_MAX;

  // True when v lies outside the signed WIDTH-bit range.
  function automatic logic clipped(input logic signed [WIDTH:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  // Clamp v into the signed WIDTH-bit range, kept sign-extended on WIDTH+1.
  function automatic logic [WIDTH:0] fit(input logic signed [WIDTH:0] v);
    logic [WIDTH:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX;
    end else if (v < SAT_MIN) begin
      r = SAT_MIN;
    end else begin
      r = v;
    end
    return r;
  endfunction
`endif

  // Phase and frame counters advance only on accepted beats.
  always_comb begin
    phase_d = phase_q;
    frame_d = frame_q;
    if (accept) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      frame_d = (frame_q == FR_LAST) ? '0 : frame_q + FW'(1);
    end else begin
      phase_d = phase_q;
      frame_d = frame_q;
    end
  end

  // Butterfly datapath; data outputs hold when no BFLY beat is accepted.
  always_comb begin
    sum_re_d  = sum_re_q;
    sum_im_d  = sum_im_q;
    diff_re_d = diff_re_q;
    diff_im_d = diff_im_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    sat_d     = 1'b0;
    sr        = '0;
    si        = '0;
    dr        = '0;
    di        = '0;
    if (accept && in_bfly) begin
      valid_d = 1'b1;
      done_d  = (frame_q == FR_LAST);
      for (int l = 0; l < LANES; l++) begin
        sr = sext(buf_re_q[slot][l]) + sext(bus.din_re[l]);
        si = sext(buf_im_q[slot][l]) + sext(bus.din_im[l]);
        dr = sext(buf_re_q[slot][l]) - sext(bus.din_re[l]);
        di = sext(buf_im_q[slot][l]) - sext(bus.din_im[l]);
`ifdef FFT_STAGE01_SAT_EN
        sum_re_d[l]  = fit(sr);
        sum_im_d[l]  = fit(si);
        diff_re_d[l] = fit(dr);
        diff_im_d[l] = fit(di);
        sat_d = sat_d | clipped(sr) | clipped(si) | clipped(dr) | clipped(di);
`else
        sum_re_d[l]  = sr;
        sum_im_d[l]  = si;
        diff_re_d[l] = dr;
        diff_im_d[l] = di;
`endif
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      frame_q   <= '0;
      sum_re_q  <= '0;
      sum_im_q  <= '0;
      diff_re_q <= '0;
      diff_im_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      frame_q   <= frame_d;
      sum_re_q  <= sum_re_d;
      sum_im_q  <= sum_im_d;
      diff_re_q <= diff_re_d;
      diff_im_q <= diff_im_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
    end
  end

  // Delay buffer: no reset needed, every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (!rst && accept && !in_bfly) begin
      buf_re_q[slot] <= bus.din_re;
      buf_im_q[slot] <= bus.din_im;
    end
  end

  assign bus.dout_sum_re  = sum_re_q;
  assign bus.dout_sum_im  = sum_im_q;
  assign bus.dout_diff_re = diff_re_q;
  assign bus.dout_diff_im = diff_im_q;
  assign bus.dout_valid   = valid_q;
  assign bus.frame_done   = done_q;
  assign bus.sat_hit      = sat_q;

endmodule

// File: tb/tb_fft_stage01_bfly.sv
// ---------------------------------------------------------------------------
// tb_fft_stage01_bfly
// Scoreboard bench for fft_stage01_bfly. The driver pushes the hand-computed
// result of every BFLY beat (with the cycle it must appear in) into a queue;
// a negedge monitor pops and compares whenever dout_valid is seen, and checks
// that data holds while dout_valid is low.
// A-half beats carry im = lane index, B-half beats carry im = 3, so every
// lane expects sum_im = lane+3 and diff_im = lane-3.
// ---------------------------------------------------------------------------
module tb_fft_stage01_bfly;
  localparam int WIDTH = 10;
  localparam int LANES = 16;

  typedef logic [LANES-1:0][WIDTH:0] res_t;
  typedef struct {
    int due;
    int s;
    int d;
    bit done;
    bit sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t last_e;
  bit   have_last = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage01_bfly_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  fft_stage01_bfly #(
    .WIDTH(WIDTH), .LANES(LANES), .DIST_CYC(8), .FRAME_CYC(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected lane l value = base + coef*l; reports the first bad lane.
  task automatic chk_lanes(input string name, input res_t vals, input int base, input int coef);
    int bad = 0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (int'($signed(vals[l])) != base + coef * l) bad = l;
    end
    chk($sformatf("%s[lane %0d]", name, bad), int'($signed(vals[bad])), base + coef * bad);
  endtask

  task automatic drive(input logic v, input int re, input bit im_lane);
    @(posedge clk);
    #1;
    bus.din_valid = v;
    for (int l = 0; l < LANES; l++) begin
      bus.din_re[l] = WIDTH'(re);
      bus.din_im[l] = im_lane ? WIDTH'(l) : WIDTH'(3);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.din_valid = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      bus.din_re[l] = WIDTH'(77);
      bus.din_im[l] = WIDTH'(-77);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_sat_hit", bus.sat_hit, 0);
    chk_lanes("rst_sum_re", bus.dout_sum_re, 0, 0);
    chk_lanes("rst_sum_im", bus.dout_sum_im, 0, 0);
    chk_lanes("rst_diff_re", bus.dout_diff_re, 0, 0);
    chk_lanes("rst_diff_im", bus.dout_diff_im, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.din_valid = 1'b0;
  endtask

  // One 16-beat block: A_k = a0 + a_st*k, B_k = b0 + b_st*k (re, all lanes).
  task automatic run_block(input int a0, input int a_st, input int b0, input int b_st,
                           input int s0, input int s_st, input int d0, input int d_st,
                           input bit gap, input bit done_last, input bit sat);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, a0 + a_st * k, 1'b1);
      if (gap) drive(1'b0, 0, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, b0 + b_st * k, 1'b0);
      exp_q.push_back('{cyc + 1, s0 + s_st * k, d0 + d_st * k, done_last && (k == 7), sat});
      if (gap) drive(1'b0, 0, 1'b0);
    end
    drive(1'b0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_size", exp_q.size(), 0);
  endtask

  // Monitor: compare popped expectations on dout_valid, check hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      have_last = 1'b0;
    end else if (bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dout_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("valid_cycle", cyc, mon_e.due);
        chk("frame_done", bus.frame_done, int'(mon_e.done));
        chk("sat_hit", bus.sat_hit, int'(mon_e.sat));
        chk_lanes("sum_re", bus.dout_sum_re, mon_e.s, 0);
        chk_lanes("diff_re", bus.dout_diff_re, mon_e.d, 0);
        chk_lanes("sum_im", bus.dout_sum_im, 3, 1);
        chk_lanes("diff_im", bus.dout_diff_im, -3, 1);
        last_e = mon_e;
        have_last = 1'b1;
      end
    end else begin
      chk("idle_frame_done", bus.frame_done, 0);
      if (have_last) begin
        chk_lanes("hold_sum_re", bus.dout_sum_re, last_e.s, 0);
        chk_lanes("hold_diff_re", bus.dout_diff_re, last_e.d, 0);
        chk_lanes("hold_sum_im", bus.dout_sum_im, 3, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.din_re = '0;
    bus.din_im = '0;
    do_reset();

    // Frame 0: continuous block then gapped block (closes the frame).
    run_block(100, 0, -50, 0, 50, 0, 150, 0, 1'b0, 1'b0, 1'b0);
    run_block(100, 0, -50, 0, 50, 0, 150, 0, 1'b1, 1'b1, 1'b0);
    // Frame 1: slot ordering (A=10k, B=k) then extremes.
    run_block(0, 10, 0, 1, 0, 11, 0, 9, 1'b0, 1'b0, 1'b0);
`ifdef FFT_STAGE01_SAT_EN
    run_block(511, 0, -512, 0, -1, 0, 511, 0, 1'b0, 1'b1, 1'b1);
`else
    run_block(511, 0, -512, 0, -1, 0, 1023, 0, 1'b0, 1'b1, 1'b0);
`endif
    drain();

    // Mid-block reset: five FILL beats, then reset discards them.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 123, 1'b1);
    drive(1'b0, 0, 1'b0);
    do_reset();

    // Fresh frame after reset, then the start of the following frame.
    run_block(7, 0, 2, 0, 9, 0, 5, 0, 1'b0, 1'b0, 1'b0);
    run_block(-20, 0, 30, 0, 10, 0, -50, 0, 1'b0, 1'b1, 1'b0);
    run_block(1, 0, 1, 0, 2, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
